// File: rtl/c432_grant_sequencer.sv
// Qualifies c432 decoder grants (N421 pending) over STABLE samples; one event per grant, pushed STABLE edges after irq_in settles.
// Events queue in a show-ahead FIFO released by valid/ready; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.
module c432_grant_sequencer #(
  parameter int DEPTH  = 4,
  parameter int STABLE = 2,
  parameter int CNT_W  = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       irq_in,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [6:0]       out_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic [CNT_W-1:0] event_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

  typedef enum logic [1:0] {ARM, QUAL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [6:0]         s_q, cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [6:0]         mem_q [DEPTH];
  logic [6:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   evt_q, evt_d;

  logic               pending, push, push_acc, pop;
  logic [6:0]         push_dat;

  assign pending = s_q[3];

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_dat = s_q;
    case (state_q)
      ARM: begin
        if (pending) begin
          cand_d = s_q;
          if (STABLE == 1) begin
            push    = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d   = 4'd1;
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        // A mismatch drops back to ARM; the new value is re-captured next cycle.
        if (!pending || s_q != cand_q) begin
          cnt_d   = 4'd0;
          state_d = ARM;
        end else if (cnt_q == STABLE_M1) begin
          push     = 1'b1;
          push_dat = cand_q;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (!pending) begin
          cnt_d   = 4'd0;
          state_d = ARM;
        end else if (s_q != cand_q) begin
          cand_d = s_q;
          if (STABLE == 1) begin
            push = 1'b1;
          end else begin
            cnt_d   = 4'd1;
            state_d = QUAL;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop      = (level_q != '0) && out_ready;
    push_acc = push && ((level_q != LVL_W'(DEPTH)) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_acc && !pop) level_d = level_q + LVL_W'(1);
    else if (!push_acc && pop) level_d = level_q - LVL_W'(1);

    ovf_d = ovf_q;
    evt_d = evt_q;
    if (clr) begin
      ovf_d = 1'b0;
      evt_d = push_acc ? CNT_W'(1) : '0;
    end else begin
      if (push && !push_acc) ovf_d = 1'b1;
      if (push_acc && evt_q != '1) evt_d = evt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      state_q  <= ARM;
      cand_q   <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      s_q      <= irq_in;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      evt_q    <= evt_d;
    end
  end

  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;
  assign event_count = evt_q;

endmodule

// File: tb/tb_c432_grant_sequencer.sv
// Randomized and directed bench for c432_grant_sequencer against a streak-counting reference model.
module tb_c432_grant_sequencer;
  localparam int DEPTH  = 4;
  localparam int STABLE = 2;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       irq_in = '0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [6:0]       out_data;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic [CNT_W-1:0] event_count;

  int checks = 0;
  int errors = 0;

  c432_grant_sequencer #(.DEPTH(DEPTH), .STABLE(STABLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .clr(clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .fifo_level(fifo_level),
    .overflow(overflow), .event_count(event_count)
  );

  always #5 clk = ~clk;

  // Reference state: last sample, current candidate, how many matching samples seen, whether already emitted.
  logic [6:0] m_s;
  logic [6:0] m_cand;
  int         m_streak;
  bit         m_held;
  logic [6:0] mq[$];
  int         m_cnt;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_cand = '0; m_streak = 0; m_held = 0;
    mq.delete(); m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit         push, pop, acc;
    logic [6:0] pw;
    push = 0;
    pw   = m_s;
    if (!m_s[3]) begin
      m_held = 0; m_streak = 0;
    end else if (m_held) begin
      if (m_s != m_cand) begin
        m_cand = m_s;
        if (STABLE == 1) begin push = 1; pw = m_s; end
        else begin m_held = 0; m_streak = 1; end
      end
    end else if (m_streak == 0) begin
      m_cand = m_s; m_streak = 1;
    end else if (m_s != m_cand) begin
      m_streak = 0;
    end else begin
      m_streak++;
    end
    if (!m_held && m_streak >= STABLE) begin
      push = 1; pw = m_cand; m_held = 1; m_streak = 0;
    end

    pop = out_ready && (mq.size() > 0);
    acc = push && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(pw);
    if (clr) begin
      m_ovf = 0;
      m_cnt = acc ? 1 : 0;
    end else begin
      if (push && !acc) m_ovf = 1;
      if (acc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    m_s = irq_in;
  endtask

  task automatic compare();
    chk("valid", out_valid, mq.size() != 0);
    chk("level", fifo_level, mq.size());
    if (mq.size() != 0) chk("data", out_data, mq[0]);
    chk("overflow", overflow, m_ovf);
    chk("count", event_count, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", event_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("init_valid", out_valid, 0);
    chk("init_level", fifo_level, 0);
    chk("init_count", event_count, 0);
    chk("init_ovf", overflow, 0);
    chk("init_data", out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stable grant: push lands on the STABLE-th edge after the first sample.
    irq_in = 7'h0B;
    steps(2);
    chk("t1_early", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 7'h0B);
    chk("t1_count", event_count, 1);
    steps(3);
    chk("t1_held_level", fifo_level, 1);
    irq_in = 7'h00; out_ready = 1'b1;
    steps(2);
    out_ready = 1'b0;
    clear();

    // Single-cycle glitch must not qualify.
    irq_in = 7'h0F; step();
    irq_in = 7'h00; steps(4);
    chk("t2_valid", out_valid, 0);
    chk("t2_count", event_count, 0);

    // Five grants into a 4-deep FIFO with no consumer.
    for (int g = 0; g < 5; g++) begin
      irq_in = 7'h08 + 7'(g);
      steps(3);
    end
    chk("t3_level", fifo_level, 4);
    chk("t3_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", out_data, 32'h08 + 32'(i));
      step();
    end
    chk("t3_empty", out_valid, 0);
    out_ready = 1'b0;
    clear();

    // Full FIFO, push coincides with a pop.
    for (int g = 0; g < 4; g++) begin
      irq_in = 7'h08 + 7'(g);
      steps(3);
    end
    irq_in = 7'h0C;
    steps(2);
    out_ready = 1'b1;
    step();
    chk("t4_level", fifo_level, 4);
    chk("t4_ovf", overflow, 0);
    out_ready = 1'b0; irq_in = 7'h00;
    steps(2);
    out_ready = 1'b1;
    steps(6);
    out_ready = 1'b0;

    // Direct grant switch yields two events; clr leaves the FIFO alone.
    irq_in = 7'h0A; steps(3);
    irq_in = 7'h0D; steps(3);
    chk("t5_level", fifo_level, 2);
    chk("t5_head", out_data, 7'h0A);
    clear();
    chk("t5_clr_count", event_count, 0);
    chk("t5_clr_level", fifo_level, 2);

    // Reset mid-qualification with three queued entries.
    irq_in = 7'h0E; steps(3);
    irq_in = 7'h0B; steps(2);
    chk("t6_level", fifo_level, 3);
    async_reset();
    steps(2);
    chk("t6_requal", out_valid, 0);
    step();
    chk("t6_after", out_data, 7'h0B);

    // Randomized phase.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: irq_in = 7'h00;
          1: irq_in = 7'($urandom);
          default: irq_in = 7'($urandom) | 7'h08;
        endcase
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step();
      clr = 1'b0;
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
